// File: rtl/mcu_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// Covers FSM states, opcodes and the datapath mux select codes.
package mcu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } state_t;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_I_IMM = 2'd1;
    localparam logic [1:0] SRCB_S_IMM = 2'd2;
    localparam logic [1:0] SRCB_PC    = 2'd3;

    localparam logic [2:0] PCS_PC4    = 3'd0;
    localparam logic [2:0] PCS_JALR   = 3'd1;
    localparam logic [2:0] PCS_BRANCH = 3'd2;
    localparam logic [2:0] PCS_JAL    = 3'd3;
    localparam logic [2:0] PCS_MTVEC  = 3'd4;
    localparam logic [2:0] PCS_MEPC   = 3'd5;

    localparam logic [1:0] WR_PC4   = 2'd0;
    localparam logic [1:0] WR_CSR   = 2'd1;
    localparam logic [1:0] WR_DOUT2 = 2'd2;
    localparam logic [1:0] WR_ALU   = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_LUI = 4'b1001;

    localparam logic [31:0] INSN_MRET = 32'h30200073;

endpackage

// File: rtl/cu_sequencer_if.sv
// Control-unit bundle: instruction/branch/interrupt inputs and datapath controls.
// The control unit takes the slave side; the datapath (or a bench) takes master.
interface cu_sequencer_if;
    logic [31:0] ir;
    logic        br_eq;
    logic        br_lt;
    logic        br_ltu;
    logic        intr;
    logic        csr_mie;

    logic        rst_out;
    logic        pcWrite;
    logic        regWrite;
    logic        memRDEN1;
    logic        memRDEN2;
    logic        memWE2;
    logic        alu_srcA;
    logic [1:0]  alu_srcB;
    logic [3:0]  alu_fun;
    logic [2:0]  pcSource;
    logic [1:0]  rf_wr_sel;
    logic        int_taken;
    logic        illegal_op;

    modport master (
        output ir, br_eq, br_lt, br_ltu, intr, csr_mie,
        input  rst_out, pcWrite, regWrite, memRDEN1, memRDEN2, memWE2,
               alu_srcA, alu_srcB, alu_fun, pcSource, rf_wr_sel, int_taken, illegal_op
    );

    modport slave (
        input  ir, br_eq, br_lt, br_ltu, intr, csr_mie,
        output rst_out, pcWrite, regWrite, memRDEN1, memRDEN2, memWE2,
               alu_srcA, alu_srcB, alu_fun, pcSource, rf_wr_sel, int_taken, illegal_op
    );
endinterface

// File: rtl/cu_decoder.sv
// Combinational instruction decode: select fields per state plus the EXEC-cycle
// strobe requests that the sequencer gates.
module cu_decoder
    import mcu_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  state_t      state,
    output logic        alu_srcA,
    output logic [1:0]  alu_srcB,
    output logic [3:0]  alu_fun,
    output logic [2:0]  pcSource,
    output logic [1:0]  rf_wr_sel,
    output logic        reg_wr_req,
    output logic        mem_rd_req,
    output logic        mem_we_req,
    output logic        is_load,
    output logic        illegal
);

    logic [2:0] funct3;
    logic       branch_taken;

    assign funct3 = ir[14:12];

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = br_eq;
            3'b001:  branch_taken = !br_eq;
            3'b100:  branch_taken = br_lt;
            3'b101:  branch_taken = !br_lt;
            3'b110:  branch_taken = br_ltu;
            3'b111:  branch_taken = !br_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_srcA   = 1'b0;
        alu_srcB   = SRCB_RS2;
        alu_fun    = ALU_ADD;
        pcSource   = PCS_PC4;
        rf_wr_sel  = WR_PC4;
        reg_wr_req = 1'b0;
        mem_rd_req = 1'b0;
        mem_we_req = 1'b0;
        is_load    = 1'b0;
        illegal    = 1'b0;
        case (state)
            ST_EXEC: begin
                case (opcode_t'(ir[6:0]))
                    OPC_LUI: begin
                        alu_srcA   = 1'b1;
                        alu_fun    = ALU_LUI;
                        rf_wr_sel  = WR_ALU;
                        reg_wr_req = 1'b1;
                    end
                    OPC_AUIPC: begin
                        alu_srcA   = 1'b1;
                        alu_srcB   = SRCB_PC;
                        rf_wr_sel  = WR_ALU;
                        reg_wr_req = 1'b1;
                    end
                    OPC_OP: begin
                        alu_fun    = {ir[30], funct3};
                        rf_wr_sel  = WR_ALU;
                        reg_wr_req = 1'b1;
                    end
                    // Only the shift-right immediates use ir[30] as a funct bit;
                    // elsewhere it is just immediate data.
                    OPC_OP_IMM: begin
                        alu_srcB   = SRCB_I_IMM;
                        alu_fun    = (funct3 == 3'b101) ? {ir[30], funct3} : {1'b0, funct3};
                        rf_wr_sel  = WR_ALU;
                        reg_wr_req = 1'b1;
                    end
                    OPC_JAL: begin
                        pcSource   = PCS_JAL;
                        reg_wr_req = 1'b1;
                    end
                    OPC_JALR: begin
                        pcSource   = PCS_JALR;
                        reg_wr_req = 1'b1;
                    end
                    OPC_BRANCH: pcSource = branch_taken ? PCS_BRANCH : PCS_PC4;
                    OPC_LOAD: begin
                        alu_srcB   = SRCB_I_IMM;
                        mem_rd_req = 1'b1;
                        is_load    = 1'b1;
                    end
                    OPC_STORE: begin
                        alu_srcB   = SRCB_S_IMM;
                        mem_we_req = 1'b1;
                    end
                    OPC_SYSTEM: begin
                        if (ir == INSN_MRET) begin
                            pcSource = PCS_MEPC;
                        end else if (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b011) begin
                            rf_wr_sel  = WR_CSR;
                            reg_wr_req = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            ST_WB: begin
                alu_srcB  = SRCB_I_IMM;
                rf_wr_sel = WR_DOUT2;
            end
            ST_INTR: pcSource = PCS_MTVEC;
            default: ;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// Multicycle RV32I control FSM: fetch, execute, load writeback and interrupt entry.
// Select fields come from cu_decoder; strobes are gated here by state.
module cu_sequencer
    import mcu_ctrl_pkg::*;
#(
    parameter bit INTR_EN      = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    cu_sequencer_if.slave  bus
);

    state_t state, next_state;

    logic       dec_srcA;
    logic [1:0] dec_srcB;
    logic [3:0] dec_fun;
    logic [2:0] dec_pcs;
    logic [1:0] dec_wr_sel;
    logic       reg_wr_req, mem_rd_req, mem_we_req, is_load, illegal;
    logic       intr_req;

    cu_decoder u_decoder (
        .ir         (bus.ir),
        .br_eq      (bus.br_eq),
        .br_lt      (bus.br_lt),
        .br_ltu     (bus.br_ltu),
        .state      (state),
        .alu_srcA   (dec_srcA),
        .alu_srcB   (dec_srcB),
        .alu_fun    (dec_fun),
        .pcSource   (dec_pcs),
        .rf_wr_sel  (dec_wr_sel),
        .reg_wr_req (reg_wr_req),
        .mem_rd_req (mem_rd_req),
        .mem_we_req (mem_we_req),
        .is_load    (is_load),
        .illegal    (illegal)
    );

    assign bus.alu_srcA  = dec_srcA;
    assign bus.alu_srcB  = dec_srcB;
    assign bus.alu_fun   = dec_fun;
    assign bus.pcSource  = dec_pcs;
    assign bus.rf_wr_sel = dec_wr_sel;

    assign intr_req = INTR_EN && bus.intr && bus.csr_mie;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= next_state;
    end

    // Interrupts are only sampled on the last cycle of an instruction, after its
    // PC update, so the CSR block captures the next PC as MEPC.
    always_comb begin
        next_state     = state;
        bus.rst_out    = 1'b0;
        bus.pcWrite    = 1'b0;
        bus.regWrite   = 1'b0;
        bus.memRDEN1   = 1'b0;
        bus.memRDEN2   = 1'b0;
        bus.memWE2     = 1'b0;
        bus.int_taken  = 1'b0;
        bus.illegal_op = 1'b0;
        case (state)
            ST_INIT: begin
                bus.rst_out = 1'b1;
                next_state  = ST_FETCH;
            end
            ST_FETCH: begin
                bus.memRDEN1 = 1'b1;
                next_state   = ST_EXEC;
            end
            ST_EXEC: begin
                bus.pcWrite    = !is_load;
                bus.regWrite   = reg_wr_req;
                bus.memRDEN2   = mem_rd_req;
                bus.memWE2     = mem_we_req;
                bus.illegal_op = illegal;
                if (is_load)                      next_state = ST_WB;
                else if (ILLEGAL_TRAP && illegal) next_state = ST_INTR;
                else if (intr_req)                next_state = ST_INTR;
                else                              next_state = ST_FETCH;
            end
            ST_WB: begin
                bus.regWrite = 1'b1;
                bus.pcWrite  = 1'b1;
                next_state   = intr_req ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                bus.int_taken = 1'b1;
                bus.pcWrite   = 1'b1;
                next_state    = ST_FETCH;
            end
            default: next_state = ST_INIT;
        endcase
    end

endmodule
